// File: rtl/button_event_pkg.sv
// Shared types and defaults for the button event decoder and its bench.
// The state enum is exported so the debug state port has a readable type.
package button_event_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRESSED,
      LONG_HELD,
      WAIT_GAP,
      PRESSED2
   } state_t;

   localparam int DEFAULT_LONG_PRESS_LIMIT   = 8;
   localparam int DEFAULT_DOUBLE_CLICK_LIMIT = 6;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_event_decoder.sv
// Decodes a clean, synchronous button level into single-cycle press, release,
// long-press and double-click pulses plus a registered held level.
module button_event_decoder
   import button_event_pkg::*;
#(
   parameter int LONG_PRESS_LIMIT   = DEFAULT_LONG_PRESS_LIMIT,
   parameter int DOUBLE_CLICK_LIMIT = DEFAULT_DOUBLE_CLICK_LIMIT
) (
   input  logic   i_clk,
   input  logic   i_rst_n,
   input  logic   i_debounced,
   output logic   o_press,
   output logic   o_release,
   output logic   o_long_press,
   output logic   o_double_click,
   output logic   o_held,
   output state_t o_state
);

   localparam int CNT_W = $clog2(max_int(LONG_PRESS_LIMIT, DOUBLE_CLICK_LIMIT) + 1);

   // cnt holds high samples seen in a press, or low samples seen in the gap.
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_LIMIT - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_CLICK_LIMIT);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             press_nxt, release_nxt, long_nxt, dc_nxt, held_nxt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state          <= IDLE;
         cnt            <= '0;
         o_press        <= 1'b0;
         o_release      <= 1'b0;
         o_long_press   <= 1'b0;
         o_double_click <= 1'b0;
         o_held         <= 1'b0;
      end else begin
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         o_press        <= press_nxt;
         o_release      <= release_nxt;
         o_long_press   <= long_nxt;
         o_double_click <= dc_nxt;
         o_held         <= held_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      long_nxt    = 1'b0;
      dc_nxt      = 1'b0;
      case (state)
         IDLE: begin
            if (i_debounced) begin
               press_nxt = 1'b1;
               cnt_nxt   = CNT_ONE;
               state_nxt = PRESSED;
            end
         end
         PRESSED, PRESSED2: begin
            if (i_debounced) begin
               if (cnt == LONG_LAST) begin
                  long_nxt  = 1'b1;
                  state_nxt = LONG_HELD;
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end else begin
               // Only a first short press opens the double-click window.
               release_nxt = 1'b1;
               cnt_nxt     = CNT_ONE;
               state_nxt   = (state == PRESSED) ? WAIT_GAP : IDLE;
            end
         end
         LONG_HELD: begin
            if (!i_debounced) begin
               release_nxt = 1'b1;
               state_nxt   = IDLE;
            end
         end
         WAIT_GAP: begin
            if (i_debounced) begin
               press_nxt = 1'b1;
               dc_nxt    = 1'b1;
               cnt_nxt   = CNT_ONE;
               state_nxt = PRESSED2;
            end else if (cnt == GAP_LAST) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      held_nxt = (state_nxt == PRESSED) || (state_nxt == PRESSED2) ||
                 (state_nxt == LONG_HELD);
   end

   assign o_state = state;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed plus randomized bench for button_event_decoder, checked against a
// run-length reference model of the press/gap rules.
module tb_button_event_decoder;
   import button_event_pkg::*;

   localparam int L = DEFAULT_LONG_PRESS_LIMIT;
   localparam int D = DEFAULT_DOUBLE_CLICK_LIMIT;

   // clock / reset
   logic   i_clk = 1'b0;
   logic   i_rst_n;
   logic   i_debounced;
   logic   o_press, o_release, o_long_press, o_double_click, o_held;
   state_t o_state;

   always #5 i_clk = ~i_clk;

   button_event_decoder #(
      .LONG_PRESS_LIMIT  (L),
      .DOUBLE_CLICK_LIMIT(D)
   ) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_debounced   (i_debounced),
      .o_press       (o_press),
      .o_release     (o_release),
      .o_long_press  (o_long_press),
      .o_double_click(o_double_click),
      .o_held        (o_held),
      .o_state       (o_state)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int n_press = 0, n_release = 0, n_long = 0, n_dc = 0;

   // reference model: run lengths of the sampled level
   bit m_prev, m_window, m_last_dc;
   int m_high_run, m_low_run;
   bit e_press, e_release, e_long, e_dc, e_held;

   function automatic void model_reset();
      m_prev = 0; m_window = 0; m_last_dc = 0;
      m_high_run = 0; m_low_run = 0;
      e_press = 0; e_release = 0; e_long = 0; e_dc = 0; e_held = 0;
   endfunction

   function automatic void model_step(input bit s);
      e_press   = s && !m_prev;
      e_release = !s && m_prev;
      e_long    = 0;
      e_dc      = 0;
      if (s) begin
         if (e_press) begin
            e_dc       = m_window && (m_low_run <= D);
            m_last_dc  = e_dc;
            m_high_run = 1;
         end else begin
            m_high_run++;
         end
         e_long = (m_high_run == L);
      end else begin
         if (e_release) begin
            m_window  = (m_high_run < L) && !m_last_dc;
            m_low_run = 1;
         end else begin
            m_low_run++;
         end
      end
      m_prev = s;
      e_held = s;
   endfunction

   // scoreboard checks
   task automatic check_bit(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      n_checks++;
      assert (o_state === IDLE) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed state %s expected IDLE", tag, o_state.name());
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_bit({tag, "_press"},   o_press,        1'b0);
      check_bit({tag, "_release"}, o_release,      1'b0);
      check_bit({tag, "_long"},    o_long_press,   1'b0);
      check_bit({tag, "_dc"},      o_double_click, 1'b0);
      check_bit({tag, "_held"},    o_held,         1'b0);
      check_idle({tag, "_state"});
   endtask

   // driver: one sample per clock, outputs checked 1 time unit after the edge
   task automatic step(input bit v);
      i_debounced = v;
      @(posedge i_clk);
      model_step(v);
      #1;
      check_bit("press",        o_press,        e_press);
      check_bit("release",      o_release,      e_release);
      check_bit("long_press",   o_long_press,   e_long);
      check_bit("double_click", o_double_click, e_dc);
      check_bit("held",         o_held,         e_held);
      n_press   += int'(o_press);
      n_release += int'(o_release);
      n_long    += int'(o_long_press);
      n_dc      += int'(o_double_click);
   endtask

   task automatic run(input bit v, input int n);
      for (int i = 0; i < n; i++) step(v);
   endtask

   task automatic clear_counts();
      n_press = 0; n_release = 0; n_long = 0; n_dc = 0;
   endtask

   initial begin
      model_reset();
      i_rst_n     = 1'b0;
      i_debounced = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      check_all_zero("in_reset");

      // input already high when reset lifts counts as a press
      @(negedge i_clk);
      i_rst_n = 1'b1;
      clear_counts();
      step(1'b1);
      check_bit("first_edge_press", o_press, 1'b1);
      check_bit("first_edge_held",  o_held,  1'b1);

      // short press: 3 high samples, 10 low
      run(1'b1, 2);
      run(1'b0, 10);
      check_int("short_press_cnt",   n_press,   1);
      check_int("short_release_cnt", n_release, 1);
      check_int("short_long_cnt",    n_long,    0);
      check_int("short_dc_cnt",      n_dc,      0);
      check_idle("short_final");

      // long press, then a quick re-press must not be a double click
      clear_counts();
      run(1'b1, 12);
      check_int("long_cnt", n_long, 1);
      run(1'b0, 2);
      run(1'b1, 1);
      check_int("after_long_dc", n_dc, 0);
      run(1'b1, 1);
      run(1'b0, 8);

      // gap of exactly D low samples is a double click
      clear_counts();
      run(1'b1, 2); run(1'b0, D); run(1'b1, 2); run(1'b0, 8);
      check_int("gap_d_dc", n_dc, 1);
      // gap of D+1 is a plain press
      clear_counts();
      run(1'b1, 2); run(1'b0, D + 1); run(1'b1, 2); run(1'b0, 8);
      check_int("gap_d1_dc",    n_dc,    0);
      check_int("gap_d1_press", n_press, 2);

      // triple click yields one double click
      clear_counts();
      run(1'b1, 2); run(1'b0, 3); run(1'b1, 2); run(1'b0, 3); run(1'b1, 2);
      run(1'b0, 8);
      check_int("triple_dc",    n_dc,    1);
      check_int("triple_press", n_press, 3);

      // reset mid-gap clears the window and emits no release
      run(1'b1, 2); run(1'b0, 2);
      #2;
      i_rst_n = 1'b0;
      #1;
      check_all_zero("mid_gap_reset");
      model_reset();
      @(negedge i_clk);
      i_rst_n = 1'b1;
      clear_counts();
      step(1'b0);
      step(1'b1);
      check_bit("post_reset_press", o_press,        1'b1);
      check_bit("post_reset_dc",    o_double_click, 1'b0);
      check_int("post_reset_release_cnt", n_release, 0);
      run(1'b1, 1); run(1'b0, 8);

      // randomized run lengths straddling both limits
      for (int r = 0; r < 40; r++) begin
         run(1'b1, $urandom_range(1, L + 4));
         run(1'b0, $urandom_range(1, D + 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
